ssc_serial_peer: RTL and testbench
==================================

// Module: ssc_serial_peer
// PURPOSE
//  Far-end serial partner for the Super Serial Card's 6551: the framework-side UART that faces the card's lines.
//  Deserialises card TXD into an RX FIFO; serialises host bytes onto card RXD.
//  Flow control: drives card CTS from RX FIFO fill; gates its own TX on card RTS.
//  Fixed 8N1 at 9600 baud, matching the card's DIP setting.
// PARAMETERS
//  CLK_HZ      14318180  frequency of CLK_14M
//  BAUD        9600      line rate; DIV = (CLK_HZ + BAUD/2) / BAUD = 1491 cycles per bit
//  DEPTH       16        RX FIFO entries, power of 2, >= 4
//  CTS_MARGIN  2         SSC_CTS_N goes high when count >= DEPTH - CTS_MARGIN
// PORTS
//  CLK_14M         in   1  sole clock
//  RESET           in   1  asynchronous, active-high
//  SSC_TXD         in   1  card UART_TXD (idle high)
//  SSC_RTS_N       in   1  card UART_RTS; low = card ready to receive
//  SSC_RXD         out  1  to card UART_RXD (idle high)
//  SSC_CTS_N       out  1  to card UART_CTS; low = peer ready to receive
//  RX_DATA         out  8  head of RX FIFO (show-ahead)
//  RX_VALID        out  1  FIFO non-empty
//  RX_READY        in   1  host pop; pop when RX_VALID & RX_READY
//  TX_DATA         in   8  byte to send
//  TX_VALID        in   1  host offer
//  TX_READY        out  1  byte accepted when TX_VALID & TX_READY
//  RX_FRAMING_ERR  out  1  one-cycle pulse: stop bit sampled low
//  RX_OVERRUN      out  1  one-cycle pulse: byte dropped, FIFO full
// BEHAVIOUR
//  Reset values: SSC_RXD=1, SSC_CTS_N=0, RX_VALID=0, RX_DATA=0, TX_READY=0, both error pulses=0.
//  Reset also: FIFO empty, both FSMs IDLE, synchronisers=1.
//  Reset asserted mid-frame: the frame is aborted, SSC_RXD goes high at once, and no partial byte is pushed.
//  SSC_TXD and SSC_RTS_N each pass through a 2-flop synchroniser. All RX/TX decisions use the synced values.
//  RX FSM: IDLE -> START -> DATA -> STOP -> (WAIT_HIGH) -> IDLE
//   IDLE: synced line low -> START; bit counter loads DIV/2.
//   START: at expiry, sample the line.
//    - high = glitch: back to IDLE, nothing reported.
//    - low: enter DATA; counter loads DIV.
//   DATA: sample 8 bits at DIV spacing, LSB first.
//   STOP: sample at mid-bit.
//    - high: push the byte; go to IDLE.
//    - low: pulse RX_FRAMING_ERR, discard the byte, go to WAIT_HIGH.
//   WAIT_HIGH: stay until synced line high, then IDLE (covers break).
//  RX FIFO:
//   - The byte is visible on RX_VALID/RX_DATA the cycle after the stop sample.
//   - A push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
//   - Otherwise pulse RX_OVERRUN, drop the new byte, and leave FIFO contents unchanged.
//   - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
//  CTS hysteresis (registered, updates the cycle after the count changes):
//   - SSC_CTS_N -> 1 when count >= DEPTH - CTS_MARGIN.
//   - SSC_CTS_N -> 0 when count <= DEPTH/2.
//   - Otherwise it holds.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE
//   - Each bit lasts exactly DIV cycles.
//   - TX_READY = (state == IDLE) & (synced SSC_RTS_N == 0).
//   - On accept, the start bit is driven from the next cycle. Data is sent LSB first, then 1 stop bit.
//   - TX_READY reasserts in the cycle after the last stop cycle. Minimum frame-to-frame spacing is 10*DIV + 1 cycles.
//   - RTS_N rising mid-frame does not abort the frame; it only blocks the next accept.
// STRUCTURE
//  Shared package/header (ssc_pkg): SSC_DATA_BITS=8, SSC_STOP_BITS=1, the DIV rounding function, and the RX/TX state encodings.
//  Sub-module ssc_byte_fifo (DEPTH, show-ahead, push/pop/count/full/empty).
//  Both FSMs and the synchronisers are inline.
// TESTING
//  1. Drive 0x55 8N1 on SSC_TXD at DIV=1491 -> RX_VALID=1, RX_DATA=0x55.
//     RX_VALID rises 9.5*1491 + 2 sync cycles (+/-1) after the start edge.
//  2. SSC_RTS_N=0, offer TX_DATA=0xA3 -> SSC_RXD: low 1491 cycles, then bits 1,1,0,0,0,1,0,1, then high.
//     TX_READY returns 14911 cycles after the accept.
//  3. 200-cycle low glitch on SSC_TXD -> no push, no error pulse, RX FSM back in IDLE.
//  4. Frame 0x00 with stop bit low held 5*DIV -> one RX_FRAMING_ERR pulse, no push.
//     A following valid 0x41 is received correctly.
//  5. DEPTH=16, send 17 bytes 0x00..0x10 with no pops:
//     - SSC_CTS_N=1 after the 14th byte.
//     - RX_OVERRUN pulses on byte 0x10; FIFO holds 0x00..0x0F.
//     - Pop 8 bytes -> SSC_CTS_N=0.
//  6. SSC_RTS_N=1 -> TX_READY stays 0 with TX_VALID high.
//     Then assert RESET mid-TX-frame -> SSC_RXD=1 immediately, all outputs at reset values.

Source files
------------

// File: rtl/ssc_pkg.sv
// ---------------------------------------------------------------------------
// ssc_pkg
// Shared definitions for the Super Serial Card far-end peer: character
// format, baud divisor rounding, and the RX/TX state encodings.
// No ports (package).
// ---------------------------------------------------------------------------
package ssc_pkg;

  localparam int SSC_DATA_BITS = 8;
  localparam int SSC_STOP_BITS = 1;
  localparam int SSC_BIT_W     = $clog2(SSC_DATA_BITS);

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/ssc_serial_peer_if.sv
// ---------------------------------------------------------------------------
// ssc_serial_peer_if
// Host-side byte streams of the serial peer.
//   RX_DATA/RX_VALID/RX_READY : received bytes, show-ahead, pop on VALID&READY
//   TX_DATA/TX_VALID/TX_READY : bytes to send, accepted on VALID&READY
//   RX_FRAMING_ERR/RX_OVERRUN : one-cycle receive error pulses
// master = host side, slave = the peer.
// ---------------------------------------------------------------------------
interface ssc_serial_peer_if;
  import ssc_pkg::*;

  logic [SSC_DATA_BITS-1:0] RX_DATA;
  logic                     RX_VALID;
  logic                     RX_READY;
  logic [SSC_DATA_BITS-1:0] TX_DATA;
  logic                     TX_VALID;
  logic                     TX_READY;
  logic                     RX_FRAMING_ERR;
  logic                     RX_OVERRUN;

  modport master (
    input  RX_DATA, RX_VALID, TX_READY, RX_FRAMING_ERR, RX_OVERRUN,
    output RX_READY, TX_DATA, TX_VALID
  );

  modport slave (
    output RX_DATA, RX_VALID, TX_READY, RX_FRAMING_ERR, RX_OVERRUN,
    input  RX_READY, TX_DATA, TX_VALID
  );

endinterface

// File: rtl/ssc_byte_fifo.sv
// ---------------------------------------------------------------------------
// ssc_byte_fifo
// Show-ahead FIFO, DEPTH entries (power of 2). The caller qualifies push and
// pop: push only when not full or popping in the same cycle, pop only when
// not empty.
//   CLK_14M, RESET  clock, asynchronous active-high reset
//   push/push_data  write one entry
//   pop             consume the head entry
//   head            current head (0 while empty)
//   count           fill level, 0..DEPTH
//   full/empty      fill flags
// ---------------------------------------------------------------------------
module ssc_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     CLK_14M,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array is deliberately left out of reset; only pointers
  // and count define which entries are valid, and a resettable array would
  // turn cheap RAM into a bank of flops.
  always_ff @(posedge CLK_14M) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  // Gated so the head reads 0 out of reset instead of uninitialised storage.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ssc_serial_peer.sv
// ---------------------------------------------------------------------------
// ssc_serial_peer
// Far-end UART partner for the Super Serial Card 6551, fixed 8N1.
// Deserialises card TXD into an RX FIFO, serialises host bytes onto card RXD,
// drives card CTS from RX FIFO fill and gates its own TX on card RTS.
//   CLK_14M    sole clock
//   RESET      asynchronous, active-high
//   SSC_TXD    card UART_TXD (idle high)
//   SSC_RTS_N  card UART_RTS, low = card ready to receive
//   SSC_RXD    to card UART_RXD (idle high)
//   SSC_CTS_N  to card UART_CTS, low = peer ready to receive
//   host       byte streams and error pulses (ssc_serial_peer_if.slave)
// ---------------------------------------------------------------------------
module ssc_serial_peer
  import ssc_pkg::*;
#(
  parameter int CLK_HZ     = 14318180,
  parameter int BAUD       = 9600,
  parameter int DEPTH      = 16,
  parameter int CTS_MARGIN = 2
) (
  input  logic              CLK_14M,
  input  logic              RESET,
  input  logic              SSC_TXD,
  input  logic              SSC_RTS_N,
  output logic              SSC_RXD,
  output logic              SSC_CTS_N,
  ssc_serial_peer_if.slave  host
);

  localparam int DIV      = calc_div(CLK_HZ, BAUD);
  localparam int STOP_LEN = DIV * SSC_STOP_BITS;
  localparam int CNT_W    = $clog2(STOP_LEN);
  localparam int COUNT_W  = $clog2(DEPTH) + 1;

  // Counters load N-1 and expire at 0, so a load of N-1 spans N cycles.
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_LEN - 1);
  // IDLE spends one cycle noticing the synced falling edge, so the start bit
  // is sampled DIV/2 cycles after that edge appears on the synced line.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SSC_BIT_W-1:0] LAST_BIT = SSC_BIT_W'(SSC_DATA_BITS - 1);

  // -------------------------------------------------------------------------
  // Input synchronisers, reset to the idle/not-ready level
  // -------------------------------------------------------------------------
  logic txd_meta, txd_sync;
  logic rts_meta, rts_sync;

  // NOTE: every clocked block uses non-blocking assignments so that each
  // flop samples the value from before the edge; with blocking ones the
  // two synchroniser stages would collapse into one.
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      txd_meta <= 1'b1;
      txd_sync <= 1'b1;
      rts_meta <= 1'b1;
      rts_sync <= 1'b1;
    end else begin
      txd_meta <= SSC_TXD;
      txd_sync <= txd_meta;
      rts_meta <= SSC_RTS_N;
      rts_sync <= rts_meta;
    end
  end

  // -------------------------------------------------------------------------
  // RX FIFO
  // -------------------------------------------------------------------------
  logic                     rx_push;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [SSC_DATA_BITS-1:0] fifo_head;
  logic [COUNT_W-1:0]       fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [SSC_DATA_BITS-1:0] rx_shift;

  assign fifo_pop  = host.RX_READY && !fifo_empty;
  // A pop in the same cycle frees the slot the new byte lands in.
  assign fifo_push = rx_push && (!fifo_full || fifo_pop);

  ssc_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SSC_DATA_BITS)
  ) u_fifo (
    .CLK_14M   (CLK_14M),
    .RESET     (RESET),
    .push      (fifo_push),
    .push_data (rx_shift),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign host.RX_DATA  = fifo_head;
  assign host.RX_VALID = !fifo_empty;

  // -------------------------------------------------------------------------
  // RX FSM
  // -------------------------------------------------------------------------
  rx_state_e                rx_state, rx_state_d;
  logic [CNT_W-1:0]         rx_cnt, rx_cnt_d;
  logic [SSC_BIT_W-1:0]     rx_bit, rx_bit_d;
  logic [SSC_DATA_BITS-1:0] rx_shift_d;
  logic                     rx_tick;
  logic                     rx_frame_bad;
  logic                     framing_err_q;
  logic                     overrun_q;

  assign rx_tick = (rx_cnt == '0);

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    rx_bit_d     = rx_bit;
    rx_shift_d   = rx_shift;
    rx_push      = 1'b0;
    rx_frame_bad = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!txd_sync) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end else if (txd_sync) begin
          rx_state_d = RX_IDLE;              // glitch, ignored silently
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = DIV_LOAD;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end else begin
          rx_shift_d = {txd_sync, rx_shift[SSC_DATA_BITS-1:1]};   // LSB first
          rx_cnt_d   = DIV_LOAD;
          rx_bit_d   = rx_bit + SSC_BIT_W'(1);
          if (rx_bit == LAST_BIT) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!rx_tick) begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end else if (txd_sync) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_frame_bad = 1'b1;
          rx_state_d   = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        // Holds through a break so a long low line is not seen as new frames.
        if (txd_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_state      <= rx_state_d;
      rx_cnt        <= rx_cnt_d;
      rx_bit        <= rx_bit_d;
      rx_shift      <= rx_shift_d;
      framing_err_q <= rx_frame_bad;
      overrun_q     <= rx_push && fifo_full && !fifo_pop;
    end
  end

  assign host.RX_FRAMING_ERR = framing_err_q;
  assign host.RX_OVERRUN     = overrun_q;

  // -------------------------------------------------------------------------
  // CTS hysteresis: stop the card near full, release at half
  // -------------------------------------------------------------------------
  logic cts_n_q;

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      cts_n_q <= 1'b0;
    end else if (fifo_count >= COUNT_W'(DEPTH - CTS_MARGIN)) begin
      cts_n_q <= 1'b1;
    end else if (fifo_count <= COUNT_W'(DEPTH / 2)) begin
      cts_n_q <= 1'b0;
    end
  end

  assign SSC_CTS_N = cts_n_q;

  // -------------------------------------------------------------------------
  // TX FSM
  // -------------------------------------------------------------------------
  tx_state_e                tx_state, tx_state_d;
  logic [CNT_W-1:0]         tx_cnt, tx_cnt_d;
  logic [SSC_BIT_W-1:0]     tx_bit, tx_bit_d;
  logic [SSC_DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                     tx_line, tx_line_d;
  logic                     tx_tick;
  logic                     tx_ready;

  assign tx_tick  = (tx_cnt == '0);
  // RTS is only consulted here, so a mid-frame RTS change never aborts a frame.
  assign tx_ready = (tx_state == TX_IDLE) && !rts_sync;

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_line_d  = tx_line;
    unique case (tx_state)
      TX_IDLE: begin
        if (host.TX_VALID && tx_ready) begin
          tx_state_d = TX_START;
          tx_shift_d = host.TX_DATA;
          tx_cnt_d   = DIV_LOAD;
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        if (!tx_tick) begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end else begin
          tx_state_d = TX_DATA;
          tx_line_d  = tx_shift[0];
          tx_shift_d = tx_shift >> 1;
          tx_bit_d   = '0;
          tx_cnt_d   = DIV_LOAD;
        end
      end
      TX_DATA: begin
        if (!tx_tick) begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end else begin
          tx_bit_d = tx_bit + SSC_BIT_W'(1);
          if (tx_bit == LAST_BIT) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
            tx_cnt_d   = STOP_LOAD;
          end else begin
            tx_line_d  = tx_shift[0];
            tx_shift_d = tx_shift >> 1;
            tx_cnt_d   = DIV_LOAD;
          end
        end
      end
      TX_STOP: begin
        if (!tx_tick) tx_cnt_d = tx_cnt - CNT_ONE;
        else          tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // The line is a flop with asynchronous set, so reset idles it immediately.
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
    end
  end

  assign SSC_RXD       = tx_line;
  assign host.TX_READY = tx_ready;

endmodule

// File: tb/tb_ssc_serial_peer.sv
// ---------------------------------------------------------------------------
// tb_ssc_serial_peer
// Directed bench for ssc_serial_peer. The line rate is raised so one bit is
// 16 clocks (DIV = (14318180 + 460800) / 921600 = 16); all expected timings
// below are the specified formulas evaluated at DIV = 16.
// ---------------------------------------------------------------------------
module tb_ssc_serial_peer;
  import ssc_pkg::*;

  localparam int CLK_HZ     = 14318180;
  localparam int BAUD       = 921600;
  localparam int DIV        = 16;
  localparam int DEPTH      = 16;
  localparam int CTS_MARGIN = 2;

  logic CLK_14M = 1'b0;
  logic RESET;
  logic SSC_TXD;
  logic SSC_RTS_N;
  logic SSC_RXD;
  logic SSC_CTS_N;

  ssc_serial_peer_if bus ();

  ssc_serial_peer #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DEPTH      (DEPTH),
    .CTS_MARGIN (CTS_MARGIN)
  ) dut (
    .CLK_14M   (CLK_14M),
    .RESET     (RESET),
    .SSC_TXD   (SSC_TXD),
    .SSC_RTS_N (SSC_RTS_N),
    .SSC_RXD   (SSC_RXD),
    .SSC_CTS_N (SSC_CTS_N),
    .host      (bus)
  );

  always #5 CLK_14M = ~CLK_14M;

  int n_checks = 0;
  int n_fails  = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  // Error pulse counters, sampled mid-cycle.
  always @(negedge CLK_14M) begin
    if (!RESET) begin
      if (bus.RX_FRAMING_ERR) fe_cnt++;
      if (bus.RX_OVERRUN)     ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_14M);
    #1;
  endtask

  // One 8N1 frame; stop level and length selectable, then DIV idle cycles.
  // valid_at = cycles from the start edge until RX_VALID is first seen high.
  task automatic uart_send(input logic [7:0] b, input logic stop_lvl,
                           input int stop_len, output int valid_at);
    int total;
    total    = 9 * DIV + stop_len + DIV;
    valid_at = -1;
    for (int c = 0; c < total; c++) begin
      if (c < DIV)                   SSC_TXD = 1'b0;
      else if (c < 9 * DIV)          SSC_TXD = b[(c - DIV) / DIV];
      else if (c < 9 * DIV + stop_len) SSC_TXD = stop_lvl;
      else                           SSC_TXD = 1'b1;
      step();
      if (valid_at < 0 && bus.RX_VALID) valid_at = c + 1;
    end
  endtask

  task automatic pop_one();
    bus.RX_READY = 1'b1;
    step();
    bus.RX_READY = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rxd"},      32'(SSC_RXD),            32'd1);
    check({pfx, "_cts_n"},    32'(SSC_CTS_N),          32'd0);
    check({pfx, "_rx_valid"}, 32'(bus.RX_VALID),       32'd0);
    check({pfx, "_rx_data"},  32'(bus.RX_DATA),        32'h00);
    check({pfx, "_tx_ready"}, 32'(bus.TX_READY),       32'd0);
    check({pfx, "_ferr"},     32'(bus.RX_FRAMING_ERR), 32'd0);
    check({pfx, "_ovr"},      32'(bus.RX_OVERRUN),     32'd0);
  endtask

  int         va;
  int         cyc;
  int         ready_at;
  int         low_run;
  int         hits;
  logic       run_open;
  logic [9:0] seen;
  logic [9:0] exp_frame;

  initial begin
    RESET        = 1'b1;
    SSC_TXD      = 1'b1;
    SSC_RTS_N    = 1'b1;
    bus.RX_READY = 1'b0;
    bus.TX_DATA  = 8'h00;
    bus.TX_VALID = 1'b0;

    // ---- reset state and divisor rounding --------------------------------
    repeat (3) step();
    check_reset_outputs("reset");
    check("div_9600",  32'(calc_div(14318180, 9600)), 32'd1491);
    check("div_bench", 32'(calc_div(CLK_HZ, BAUD)),   32'd16);
    RESET = 1'b0;
    repeat (3) step();

    // ---- 1: receive 0x55, latency 9.5*DIV + 2 (+/-1) = 153..155 ----------
    uart_send(8'h55, 1'b1, DIV, va);
    check($sformatf("rx_latency_%0d", va), 32'(va >= 153 && va <= 155), 32'd1);
    check("rx55_valid", 32'(bus.RX_VALID), 32'd1);
    check("rx55_data",  32'(bus.RX_DATA),  32'h55);
    check("rx55_noerr", 32'(fe_cnt + ov_cnt), 32'd0);
    pop_one();
    check("rx55_popped", 32'(bus.RX_VALID), 32'd0);

    // ---- 2: transmit 0xA3 ------------------------------------------------
    SSC_RTS_N = 1'b0;
    repeat (3) step();
    check("tx_ready_rts_low", 32'(bus.TX_READY), 32'd1);
    bus.TX_DATA  = 8'hA3;
    bus.TX_VALID = 1'b1;
    step();                       // accept edge
    bus.TX_VALID = 1'b0;
    // Cycle 0 is the accept cycle; bit k occupies cycles k*DIV+1..(k+1)*DIV.
    cyc = 1; ready_at = -1; low_run = 0; run_open = 1'b1; seen = '0;
    while (cyc <= 12 * DIV && ready_at < 0) begin
      if (bus.TX_READY) ready_at = cyc;
      if (run_open) begin
        if (SSC_RXD == 1'b0) low_run++;
        else                 run_open = 1'b0;
      end
      if ((cyc - 1) % DIV == DIV / 2 && (cyc - 1) / DIV < 10)
        seen[(cyc - 1) / DIV] = SSC_RXD;
      step();
      cyc++;
    end
    exp_frame = {1'b1, 8'hA3, 1'b0};
    check("tx_start_len", 32'(low_run),  32'(DIV));
    check("tx_frame_a3",  32'(seen),     32'(exp_frame));
    check("tx_ready_ret", 32'(ready_at), 32'(10 * DIV + 1));
    check("tx_idle_high", 32'(SSC_RXD),  32'd1);

    // ---- 3: short low glitch on TXD -------------------------------------
    SSC_TXD = 1'b0;
    repeat (3) step();
    SSC_TXD = 1'b1;
    repeat (2 * DIV) step();
    check("glitch_no_push", 32'(bus.RX_VALID),  32'd0);
    check("glitch_no_err",  32'(fe_cnt),        32'd0);
    check("glitch_idle",    32'(dut.rx_state),  32'(RX_IDLE));

    // ---- 4: framing error, then a good 0x41 ------------------------------
    uart_send(8'h00, 1'b0, 5 * DIV, va);
    check("ferr_no_push", 32'(va),           32'hFFFF_FFFF);
    check("ferr_pulses",  32'(fe_cnt),       32'd1);
    check("ferr_empty",   32'(bus.RX_VALID), 32'd0);
    uart_send(8'h41, 1'b1, DIV, va);
    check("rx41_valid", 32'(bus.RX_VALID), 32'd1);
    check("rx41_data",  32'(bus.RX_DATA),  32'h41);
    check("rx41_no_new_err", 32'(fe_cnt),  32'd1);
    pop_one();

    // ---- 5: fill to overrun, CTS hysteresis ------------------------------
    for (int b = 0; b < 17; b++) begin
      uart_send(8'(b), 1'b1, DIV, va);
      if (b == 12) check("cts_after_13", 32'(SSC_CTS_N), 32'd0);
      if (b == 13) check("cts_after_14", 32'(SSC_CTS_N), 32'd1);
      if (b == 15) check("ovr_before_16", 32'(ov_cnt),   32'd0);
    end
    check("ovr_on_0x10",   32'(ov_cnt),       32'd1);
    check("full_head",     32'(bus.RX_DATA),  32'h00);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fifo_pop_%0d", i), 32'(bus.RX_DATA), 32'(i));
      pop_one();
      if (i == 6) check("cts_hold_9",    32'(SSC_CTS_N), 32'd1);
      if (i == 7) check("cts_release_8", 32'(SSC_CTS_N), 32'd0);
    end
    check("fifo_drained", 32'(bus.RX_VALID), 32'd0);

    // ---- 6: RTS gating, RTS mid-frame, reset mid-frame -------------------
    uart_send(8'h7E, 1'b1, DIV, va);
    check("rx7e_held", 32'(bus.RX_DATA), 32'h7E);
    SSC_RTS_N    = 1'b1;
    repeat (3) step();
    bus.TX_DATA  = 8'h00;
    bus.TX_VALID = 1'b1;
    hits = 0;
    for (int i = 0; i < 4 * DIV; i++) begin
      if (bus.TX_READY || !SSC_RXD) hits++;
      step();
    end
    check("rts_blocks_tx", 32'(hits), 32'd0);
    SSC_RTS_N = 1'b0;
    cyc = 0;
    while (!bus.TX_READY && cyc < 10) begin
      step();
      cyc++;
    end
    check("rts_reopen", 32'(bus.TX_READY), 32'd1);
    step();                       // accept edge, 0x00 frame starts
    bus.TX_VALID = 1'b0;
    repeat (DIV / 2) step();
    SSC_RTS_N = 1'b1;             // mid-frame: must not abort
    repeat (3 * DIV) step();      // now inside data bit 2
    check("rts_mid_frame", 32'(SSC_RXD), 32'd0);
    RESET = 1'b1;
    #1;
    check_reset_outputs("reset_mid_tx");
    repeat (3) step();
    RESET = 1'b0;
    repeat (2 * DIV) step();
    check("post_reset_rxd", 32'(SSC_RXD), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
